intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- External-interrupt front end directly upstream of the CP0 exception unit.
- Synchronises and debounces the five board buttons (S1..S5) and accepts a synchronous timer tick; each is captured as a latched pending bit.
- Drives CP0's ExternalInterrupt[5:0] with the masked pending vector.
- Clears the serviced source when CP0 reports that an interrupt was taken.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive stable synchronised samples required before a button's debounced state changes (min 2).
- NUM_BTN, 5, number of button sources; fixed at 5 for this design, ext_int width = NUM_BTN+1.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- btn_raw  in  5  raw asynchronous button levels; bit0=S1 .. bit4=S5, active-high
- timer_tick  in  1  synchronous single-cycle pulse from the timer, source 0
- int_mask  in  6  per-source enable (CP0 Status[15:10]); 1 = enabled
- irq_ack  in  1  single-cycle pulse: CP0 took an interrupt/exception this cycle (cp0_wen qualified by !Eret at top level)
- ext_int  out  6  to CP0 ExternalInterrupt; bit0=timer, bit1..5=S1..S5
- pending  out  6  raw unmasked pending bits, for debug/readback

Behaviour:
- Reset (async, active-high): sync flops, debounced states, counters and pending all cleared to 0; ext_int=0, pending=0 immediately.
- Button path, per bit i:
  - Two-flop synchroniser gives s_i.
  - Counter cnt_i (width $clog2(DEBOUNCE_CYCLES)) is cleared on any edge where s_i == db_i.
  - On an edge where s_i != db_i: if cnt_i == DEBOUNCE_CYCLES-1, db_i toggles and cnt_i clears; otherwise cnt_i increments.
  - Clean press latency: raw rises before edge 1 -> db_i high after edge 2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
- Event generation:
  - Button i event is the rising edge of db_i, i.e. the same clock edge on which db_i goes 0->1; sets pending[i+1] on that edge.
  - Release (db 1->0) generates no event.
  - timer_tick high on an edge sets pending[0] on that edge; no synchronisation or debounce.
- Output: ext_int = pending & int_mask, combinational from registers. Masked sources stay pending and appear when unmasked.
- Acknowledge:
  - On an edge with irq_ack=1, clear the lowest-indexed set bit of (pending & int_mask). This matches CP0's priority (bit0 highest).
  - If that vector is 0, irq_ack has no effect; an exception-only acknowledge changes nothing.
  - irq_ack held high for N cycles clears up to N sources, one per cycle.
- Simultaneous events:
  - Set and clear of the same bit on one edge: set wins, bit stays 1.
  - Set of one bit and clear of another: both apply.
  - An event on an already-pending source merges; there is no counting.
- Reset asserted mid-debounce or mid-pending: all progress discarded. After release the button must again be stable for the full window.
- A button held high across reset release produces exactly one event, 2+DEBOUNCE_CYCLES edges after reset deasserts.

Decomposition:
- Shared package: source index constants (IRQ_TIMER=0, IRQ_S1..IRQ_S5=1..5) and the CP0 ExcCode constants per source (00000, 01101..10001), so intr_ctrl and CP0 agree on priority.
- One natural sub-module: btn_debounce (synchroniser + counter + rise pulse), parameterised by DEBOUNCE_CYCLES and instantiated NUM_BTN times.
- The pending/ack priority logic stays in intr_ctrl.

Test Plan:
- DEBOUNCE_CYCLES=4, mask=6'h3F, btn_raw[0] rises before edge 1 and is held -> pending=6'b000010 and ext_int=6'b000010 after edge 6, not after edge 5; no further set while held.
- btn_raw[2] high for 3 synchronised cycles then low -> pending stays 0; cnt returns to 0.
- timer_tick on edge 10 and S3 debounced rise on edge 10 -> pending=6'b001001; irq_ack on edge 11 -> 6'b001000; irq_ack on edge 12 -> 0.
- mask=6'b111110, timer pending -> ext_int=0; irq_ack -> pending unchanged. Set mask=6'h3F -> ext_int=6'b000001.
- pending[1]=1; on one edge irq_ack=1 and a new S1 rise occur -> pending[1] remains 1.
- Async reset asserted between clock edges while pending=6'b100001 and cnt=2 -> pending=0 and ext_int=0 before the next edge. Button still held -> event 6 edges after reset release.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared interrupt source numbering and CP0 exception codes.
// Keeps intr_ctrl and CP0 in agreement on source order (bit0 = highest priority).
package intr_ctrl_pkg;

  localparam int unsigned NUM_SRC   = 6;

  // Source index within ext_int / pending
  localparam int unsigned IRQ_TIMER = 0;
  localparam int unsigned IRQ_S1    = 1;
  localparam int unsigned IRQ_S2    = 2;
  localparam int unsigned IRQ_S3    = 3;
  localparam int unsigned IRQ_S4    = 4;
  localparam int unsigned IRQ_S5    = 5;

  // CP0 ExcCode reported for each source
  localparam logic [4:0] EXC_TIMER = 5'b00000;
  localparam logic [4:0] EXC_S1    = 5'b01101;
  localparam logic [4:0] EXC_S2    = 5'b01110;
  localparam logic [4:0] EXC_S3    = 5'b01111;
  localparam logic [4:0] EXC_S4    = 5'b10000;
  localparam logic [4:0] EXC_S5    = 5'b10001;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debouncer with a rise pulse.
// Ports:
//   clock, reset  - system clock, async active-high reset
//   btn_raw_i     - raw asynchronous button level
//   rise_c        - combinational pulse, high on the edge where the debounced
//                   state goes 0->1
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic rise_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             s_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser, debounced state and stability counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      s_q     <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the window
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    rise_c = 1'b0;
    if (s_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d   = ~db_q;
        rise_c = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// External-interrupt front end feeding CP0 ExternalInterrupt.
// Ports:
//   clock, reset - system clock, async active-high reset
//   btn_raw      - raw button levels, bit0=S1 .. bit4=S5
//   timer_tick   - synchronous single-cycle timer pulse (source 0)
//   int_mask     - per-source enable, 1 = enabled
//   irq_ack      - CP0 took an interrupt/exception this cycle
//   ext_int      - pending & int_mask, to CP0
//   pending      - raw pending bits for readback
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned NUM_BTN         = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               timer_tick,
  input  logic [NUM_BTN:0]   int_mask,
  input  logic               irq_ack,
  output logic [NUM_BTN:0]   ext_int,
  output logic [NUM_BTN:0]   pending
);

  localparam int unsigned NSRC = NUM_BTN + 1;

  logic [NUM_BTN-1:0] btn_rise;
  logic [NSRC-1:0]    pend_q, pend_d;
  logic [NSRC-1:0]    set_vec, clr_vec, active;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clock     (clock),
      .reset     (reset),
      .btn_raw_i (btn_raw[i]),
      .rise_c    (btn_rise[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Ack retires the lowest enabled pending source; a same-edge set overrides it
  always_comb begin
    set_vec                   = '0;
    set_vec[IRQ_TIMER]        = timer_tick;
    set_vec[NUM_BTN:IRQ_S1]   = btn_rise;
    active                    = pend_q & int_mask;
    clr_vec                   = irq_ack ? (active & (~active + NSRC'(1))) : '0;
    pend_d                    = (pend_q & ~clr_vec) | set_vec;
  end

  assign pending = pend_q;
  assign ext_int = pend_q & int_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  localparam int unsigned D = 4;

  logic       clock;
  logic       reset;
  logic [4:0] btn_raw;
  logic       timer_tick;
  logic [5:0] int_mask;
  logic       irq_ack;
  logic [5:0] ext_int;
  logic [5:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  intr_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_BTN(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .timer_tick (timer_tick),
    .int_mask   (int_mask),
    .irq_ack    (irq_ack),
    .ext_int    (ext_int),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a button's debounced level flips once the last D
  // synchronised samples all disagree with it; raw reaches the window two edges late.
  logic [4:0]   m_r1, m_r2, m_db, m_db_nxt;
  logic [D-1:0] m_hist     [5];
  logic [D-1:0] m_hist_nxt [5];
  logic [5:0]   m_pend, m_pend_nxt, m_set, m_clr;
  logic         m_found;

  always_comb begin
    m_set    = '0;
    m_set[0] = timer_tick;
    m_db_nxt = m_db;
    for (int i = 0; i < 5; i++) begin
      m_hist_nxt[i] = {m_hist[i][D-2:0], m_r2[i]};
      if (!m_db[i] && (m_hist_nxt[i] == {D{1'b1}})) begin
        m_db_nxt[i]  = 1'b1;
        m_set[i+1]   = 1'b1;
      end else if (m_db[i] && (m_hist_nxt[i] == {D{1'b0}})) begin
        m_db_nxt[i]  = 1'b0;
      end
    end
    m_clr   = '0;
    m_found = 1'b0;
    if (irq_ack) begin
      for (int k = 0; k < 6; k++) begin
        if (!m_found && m_pend[k] && int_mask[k]) begin
          m_clr[k] = 1'b1;
          m_found  = 1'b1;
        end
      end
    end
    m_pend_nxt = (m_pend & ~m_clr) | m_set;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_r1   <= '0;
      m_r2   <= '0;
      m_db   <= '0;
      m_pend <= '0;
      for (int i = 0; i < 5; i++) m_hist[i] <= '0;
    end else begin
      m_r1   <= btn_raw;
      m_r2   <= m_r1;
      m_db   <= m_db_nxt;
      m_pend <= m_pend_nxt;
      for (int i = 0; i < 5; i++) m_hist[i] <= m_hist_nxt[i];
    end
  end

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    check("model_pending", pending, m_pend);
    check("model_ext_int", ext_int, m_pend & int_mask);
  endtask

  // Advance n clock edges, comparing against the model 1 unit after each edge
  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clock);
      #1;
      model_cmp();
      #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    btn_raw    = '0;
    timer_tick = 1'b0;
    int_mask   = 6'h3F;
    irq_ack    = 1'b0;
    #3;
    step(2);
    check("reset_pending", pending, 6'b000000);
    check("reset_ext_int", ext_int, 6'b000000);
    reset = 1'b0;

    // Clean S1 press: event after edge 6, not edge 5, once only
    btn_raw[0] = 1'b1;
    step(5);
    check("s1_edge5", pending, 6'b000000);
    step(1);
    check("s1_edge6_pend", pending, 6'b000010);
    check("s1_edge6_ext", ext_int, 6'b000010);
    step(4);
    check("s1_held", pending, 6'b000010);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    check("s1_ack", pending, 6'b000000);

    // Short S3 glitch ignored
    btn_raw[2] = 1'b1; step(3);
    btn_raw[2] = 1'b0; step(8);
    check("glitch", pending, 6'b000000);

    // Timer and S3 rise on the same edge, then two acks
    btn_raw[2] = 1'b1; step(5);
    timer_tick = 1'b1; step(1); timer_tick = 1'b0;
    check("timer_s3", pending, 6'b001001);
    irq_ack = 1'b1; step(1);
    check("ack1", pending, 6'b001000);
    step(1); irq_ack = 1'b0;
    check("ack2", pending, 6'b000000);
    btn_raw[2] = 1'b0; step(8);

    // Masked timer: hidden, not acked, appears when unmasked
    int_mask = 6'b111110;
    timer_tick = 1'b1; step(1); timer_tick = 1'b0;
    check("masked_pend", pending, 6'b000001);
    check("masked_ext", ext_int, 6'b000000);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    check("masked_ack", pending, 6'b000001);
    int_mask = 6'h3F; #1;
    check("unmask_ext", ext_int, 6'b000001);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    check("unmask_ack", pending, 6'b000000);

    // Release gives no event; ack and new rise on same edge: set wins
    btn_raw[0] = 1'b0; step(8);
    check("release", pending, 6'b000000);
    btn_raw[0] = 1'b1; step(6);
    check("s1_again", pending, 6'b000010);
    btn_raw[0] = 1'b0; step(8);
    btn_raw[0] = 1'b1; step(5);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    check("set_wins", pending, 6'b000010);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    check("set_wins_ack", pending, 6'b000000);
    btn_raw[0] = 1'b0; step(8);

    // Async reset mid-pending and mid-debounce
    btn_raw[4] = 1'b1; step(6);
    check("s5", pending, 6'b100000);
    timer_tick = 1'b1; step(1); timer_tick = 1'b0;
    check("s5_timer", pending, 6'b100001);
    btn_raw[1] = 1'b1; step(4);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pend", pending, 6'b000000);
    check("async_rst_ext", ext_int, 6'b000000);
    model_cmp();
    step(2);
    reset = 1'b0;
    step(5);
    check("post_rst_edge5", pending, 6'b000000);
    step(1);
    check("post_rst_edge6", pending, 6'b100100);
    step(6);
    check("post_rst_once", pending, 6'b100100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
